// File: rtl/ysyx_22040237_pkg.sv
// ysyx_22040237_pkg
// Shared definitions for the ysyx_22040237 load/store path:
//   - bit positions inside the 7-bit ls_info bus produced by the EXU
//   - LSU state encoding
//   - access-size (lane) encoding and the byte-mask constants per size
//   - small helpers to decode the access size, detect misalignment and
//     build the byte write mask
package ysyx_22040237_pkg;

    // ls_info_bus bit positions
    localparam int LS_INFO_W   = 7;
    localparam int LS_LOAD     = 0;
    localparam int LS_STORE    = 1;
    localparam int LS_UNSIGNED = 2;
    localparam int LS_BYTE     = 3;
    localparam int LS_HALF     = 4;
    localparam int LS_WORD     = 5;
    localparam int LS_DOUBLE   = 6;

    // LSU controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Access size, encoded as log2 of the number of bytes
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } lane_size_e;

    // Byte-lane masks for each access size before shifting to the offset
    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    // The widest size bit wins; an info word with no size bit set is
    // treated as a byte access.
    function automatic lane_size_e decode_size(input logic [LS_INFO_W-1:0] info);
        lane_size_e size;
        if (info[LS_DOUBLE])    size = SIZE_D;
        else if (info[LS_WORD]) size = SIZE_W;
        else if (info[LS_HALF]) size = SIZE_H;
        else                    size = SIZE_B;
        return size;
    endfunction

    function automatic logic is_misaligned(input lane_size_e size, input logic [2:0] offset);
        logic mis;
        case (size)
            SIZE_H:  mis = offset[0];
            SIZE_W:  mis = |offset[1:0];
            SIZE_D:  mis = |offset[2:0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // A doubleword always covers all eight lanes; narrower sizes are
    // shifted up to the byte offset inside the 8-byte beat.
    function automatic logic [7:0] lane_mask(input lane_size_e size, input logic [2:0] offset);
        logic [7:0] mask;
        case (size)
            SIZE_H:  mask = MASK_H << offset;
            SIZE_W:  mask = MASK_W << offset;
            SIZE_D:  mask = MASK_D;
            default: mask = MASK_B << offset;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_ext.sv
// ysyx_22040237_lsu_ext
// Combinational load alignment and extension. Takes the raw 8-byte beat
// returned by memory, moves the addressed lane down to bit 0, truncates it
// to the access size and sign- or zero-extends it to 64 bits.
// Ports:
//   rdata       in  64  raw memory read beat
//   offset      in  3   byte offset of the access inside the beat
//   size        in  2   access size (lane_size_e)
//   is_unsigned in  1   zero-extend instead of sign-extend
//   result      out 64  aligned, extended load value
module ysyx_22040237_lsu_ext
    import ysyx_22040237_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  lane_size_e  size,
    input  logic        is_unsigned,
    output logic [63:0] result
);

    logic [63:0] lane;

    // Shift the addressed byte lane to the bottom, then extend from the
    // top bit of the access size unless the load is unsigned.
    always_comb begin
        lane   = rdata >> {offset, 3'b000};
        result = '0;
        case (size)
            SIZE_B: result = is_unsigned ? {56'd0, lane[7:0]}
                                         : {{56{lane[7]}}, lane[7:0]};
            SIZE_H: result = is_unsigned ? {48'd0, lane[15:0]}
                                         : {{48{lane[15]}}, lane[15:0]};
            SIZE_W: result = is_unsigned ? {32'd0, lane[31:0]}
                                         : {{32{lane[31]}}, lane[31:0]};
            SIZE_D: result = lane;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// ysyx_22040237_lsu
// Load/store unit sitting between the EXU and a simple req/gnt + rvalid
// memory port. Non-memory results are passed straight to writeback one
// cycle later; loads and stores run through IDLE -> REQ -> (WAIT) -> RESP.
// Misaligned accesses skip memory and report an error; an access that
// spends TIMEOUT cycles in REQ/WAIT is abandoned with an error.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid_i / in_ready_o  EXU handshake (ready only while IDLE)
//   rd_wr_en_i, rd_idx_i     destination register write enable / index
//   alu_res_i                ALU result or effective address
//   ls_info_bus_i            load/store/unsigned/size flags
//   rs2_store_i              store data
//   mem_req_o .. mem_wmask_o memory request channel (held until mem_gnt_i)
//   mem_gnt_i                request accepted
//   mem_rvalid_i, mem_rdata_i read data return
//   wb_valid_o .. ls_err_o   one-cycle writeback pulse with its payload
module ysyx_22040237_lsu
    import ysyx_22040237_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 rd_wr_en_i,
    input  logic [4:0]           rd_idx_i,
    input  logic [63:0]          alu_res_i,
    input  logic [LS_INFO_W-1:0] ls_info_bus_i,
    input  logic [63:0]          rs2_store_i,

    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [63:0]          mem_addr_o,
    output logic [63:0]          mem_wdata_o,
    output logic [7:0]           mem_wmask_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [63:0]          mem_rdata_i,

    output logic                 wb_valid_o,
    output logic                 rd_wr_en_o,
    output logic [4:0]           rd_idx_o,
    output logic [63:0]          rd_wdata_o,
    output logic                 ls_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;

    // Access attributes captured at acceptance, used in later states
    logic [2:0]  lat_off;
    lane_size_e  lat_size;
    logic        lat_uns;
    logic        lat_load;
    logic        lat_rd_wr_en;

    // Decode of the incoming EXU request (only meaningful in IDLE)
    logic        acc_load;
    logic        acc_store;
    lane_size_e  acc_size;
    logic [2:0]  acc_off;
    logic        acc_mis;

    logic [63:0] load_data;

    // Load takes priority if the EXU ever flags both load and store.
    always_comb begin
        acc_load  = ls_info_bus_i[LS_LOAD];
        acc_store = ls_info_bus_i[LS_STORE] & ~ls_info_bus_i[LS_LOAD];
        acc_size  = decode_size(ls_info_bus_i);
        acc_off   = alu_res_i[2:0];
        acc_mis   = is_misaligned(acc_size, acc_off);
    end

    ysyx_22040237_lsu_ext u_ext (
        .rdata       (mem_rdata_i),
        .offset      (lat_off),
        .size        (lat_size),
        .is_unsigned (lat_uns),
        .result      (load_data)
    );

    // Main controller. Every output is a register updated here; the
    // writeback flags default to low so each writeback is a single-cycle
    // pulse. The timeout counter advances on every REQ/WAIT cycle and a
    // grant or read response in the final counted cycle still wins over
    // the timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_off      <= '0;
            lat_size     <= SIZE_B;
            lat_uns      <= 1'b0;
            lat_load     <= 1'b0;
            lat_rd_wr_en <= 1'b0;
            in_ready_o   <= 1'b1;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_wmask_o  <= '0;
            wb_valid_o   <= 1'b0;
            rd_wr_en_o   <= 1'b0;
            rd_idx_o     <= '0;
            rd_wdata_o   <= '0;
            ls_err_o     <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            rd_wr_en_o <= 1'b0;
            ls_err_o   <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        rd_idx_o <= rd_idx_i;
                        if (!acc_load && !acc_store) begin
                            // Plain ALU result: straight to writeback
                            wb_valid_o <= 1'b1;
                            rd_wr_en_o <= rd_wr_en_i;
                            rd_wdata_o <= alu_res_i;
                        end else begin
                            lat_off      <= acc_off;
                            lat_size     <= acc_size;
                            lat_uns      <= ls_info_bus_i[LS_UNSIGNED];
                            lat_load     <= acc_load;
                            lat_rd_wr_en <= rd_wr_en_i;
                            cnt          <= '0;
                            in_ready_o   <= 1'b0;
                            mem_we_o     <= acc_store;
                            mem_addr_o   <= {alu_res_i[63:3], 3'b000};
                            mem_wdata_o  <= rs2_store_i << {acc_off, 3'b000};
                            mem_wmask_o  <= lane_mask(acc_size, acc_off);
                            if (acc_mis) begin
                                // Never reaches memory
                                state      <= RESP;
                                wb_valid_o <= 1'b1;
                                ls_err_o   <= 1'b1;
                                rd_wdata_o <= '0;
                            end else begin
                                state     <= REQ;
                                mem_req_o <= 1'b1;
                            end
                        end
                    end
                end

                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (lat_load) begin
                            state <= WAIT;
                        end else begin
                            state      <= RESP;
                            wb_valid_o <= 1'b1;
                            rd_wdata_o <= '0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state      <= RESP;
                        mem_req_o  <= 1'b0;
                        wb_valid_o <= 1'b1;
                        ls_err_o   <= 1'b1;
                        rd_wdata_o <= '0;
                    end
                end

                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_rvalid_i) begin
                        state      <= RESP;
                        wb_valid_o <= 1'b1;
                        rd_wr_en_o <= lat_rd_wr_en;
                        rd_wdata_o <= load_data;
                    end else if (cnt == CNT_LAST) begin
                        state      <= RESP;
                        wb_valid_o <= 1'b1;
                        ls_err_o   <= 1'b1;
                        rd_wdata_o <= '0;
                    end
                end

                RESP: begin
                    state      <= IDLE;
                    in_ready_o <= 1'b1;
                end

                default: begin
                    state      <= IDLE;
                    in_ready_o <= 1'b1;
                    mem_req_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// tb_ysyx_22040237_lsu
// Self-checking bench for the LSU: directed cases for the documented
// examples plus a randomized mix of ALU, load and store operations whose
// expected results come from a byte-level model of the access rules.
module tb_ysyx_22040237_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        rd_wr_en_i;
    logic [4:0]  rd_idx_i;
    logic [63:0] alu_res_i;
    logic [6:0]  ls_info_bus_i;
    logic [63:0] rs2_store_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        wb_valid_o;
    logic        rd_wr_en_o;
    logic [4:0]  rd_idx_o;
    logic [63:0] rd_wdata_o;
    logic        ls_err_o;

    int checks = 0;
    int errors = 0;

    ysyx_22040237_lsu #(.TIMEOUT(255)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .rd_wr_en_i    (rd_wr_en_i),
        .rd_idx_i      (rd_idx_i),
        .alu_res_i     (alu_res_i),
        .ls_info_bus_i (ls_info_bus_i),
        .rs2_store_i   (rs2_store_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_wmask_o   (mem_wmask_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .wb_valid_o    (wb_valid_o),
        .rd_wr_en_o    (rd_wr_en_o),
        .rd_idx_o      (rd_idx_o),
        .rd_wdata_o    (rd_wdata_o),
        .ls_err_o      (ls_err_o)
    );

    // Free-running 10-unit clock; stimulus and sampling both happen on the
    // falling edge, half a period away from the active edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counted, and reported on mismatch
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference load result: gather the access bytes from the beat, then
    // fill the upper bytes with the sign byte for signed loads.
    function automatic logic [63:0] modelLoad(input logic [63:0] rdata, input int off,
                                              input int nbytes, input bit uns);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!uns && v[8*nbytes-1])
            for (int i = nbytes; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // Reference byte-enable mask: one bit per byte the access touches
    function automatic logic [7:0] modelMask(input int off, input int nbytes);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < nbytes; i++) m[off+i] = 1'b1;
        return m;
    endfunction

    // One complete operation. kind: 0 = ALU pass-through, 1 = load,
    // 2 = store. sz is log2 of the access size. gdly/rdly are the number of
    // idle cycles the memory waits before granting / returning data.
    task automatic applyStimulus(input int kind, input int sz, input bit uns,
                                 input logic [63:0] addr, input logic [63:0] rs2,
                                 input logic [63:0] rdata, input logic rd_en,
                                 input logic [4:0] idx, input int gdly, input int rdly);
        int nbytes;
        int off;
        bit mis;
        logic [6:0] info;
        nbytes = 1 << sz;
        off    = int'(addr[2:0]);
        mis    = (kind != 0) && ((addr % nbytes) != 0);
        info   = '0;
        info[0] = (kind == 1);
        info[1] = (kind == 2);
        info[2] = uns;
        info[3+sz] = 1'b1;

        checkOutput("in_ready_idle", in_ready_o, 1'b1);
        in_valid_i    = 1'b1;
        alu_res_i     = addr;
        rs2_store_i   = rs2;
        ls_info_bus_i = info;
        rd_wr_en_i    = rd_en;
        rd_idx_i      = idx;
        @(negedge clk);
        in_valid_i = 1'b0;

        if (kind == 0) begin
            checkOutput("alu_wb_valid", wb_valid_o, 1'b1);
            checkOutput("alu_wdata", rd_wdata_o, addr);
            checkOutput("alu_wr_en", rd_wr_en_o, rd_en);
            checkOutput("alu_idx", rd_idx_o, idx);
            checkOutput("alu_err", ls_err_o, 1'b0);
            @(negedge clk);
            checkOutput("alu_wb_pulse", wb_valid_o, 1'b0);
        end else if (mis) begin
            checkOutput("mis_wb_valid", wb_valid_o, 1'b1);
            checkOutput("mis_err", ls_err_o, 1'b1);
            checkOutput("mis_wr_en", rd_wr_en_o, 1'b0);
            checkOutput("mis_no_req", mem_req_o, 1'b0);
            @(negedge clk);
            checkOutput("mis_wb_pulse", wb_valid_o, 1'b0);
            checkOutput("mis_ready", in_ready_o, 1'b1);
        end else begin
            checkOutput("req_busy", in_ready_o, 1'b0);
            checkOutput("req_valid", mem_req_o, 1'b1);
            checkOutput("req_no_wb", wb_valid_o, 1'b0);
            checkOutput("req_addr", mem_addr_o, addr & ~64'h7);
            checkOutput("req_we", mem_we_o, (kind == 2));
            if (kind == 2) begin
                checkOutput("req_wmask", mem_wmask_o, modelMask(off, nbytes));
                checkOutput("req_wdata", mem_wdata_o, rs2 << (8*off));
            end
            repeat (gdly) begin
                @(negedge clk);
                checkOutput("req_hold", mem_req_o, 1'b1);
            end
            // A response arriving together with the grant must be dropped
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = ~rdata;
            @(negedge clk);
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (kind == 2) begin
                checkOutput("st_wb_valid", wb_valid_o, 1'b1);
                checkOutput("st_wr_en", rd_wr_en_o, 1'b0);
                checkOutput("st_err", ls_err_o, 1'b0);
                checkOutput("st_req_drop", mem_req_o, 1'b0);
            end else begin
                checkOutput("ld_wait_no_wb", wb_valid_o, 1'b0);
                checkOutput("ld_req_drop", mem_req_o, 1'b0);
                repeat (rdly) @(negedge clk);
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = rdata;
                @(negedge clk);
                mem_rvalid_i = 1'b0;
                checkOutput("ld_wb_valid", wb_valid_o, 1'b1);
                checkOutput("ld_wdata", rd_wdata_o, modelLoad(rdata, off, nbytes, uns));
                checkOutput("ld_wr_en", rd_wr_en_o, rd_en);
                checkOutput("ld_idx", rd_idx_o, idx);
                checkOutput("ld_err", ls_err_o, 1'b0);
            end
            @(negedge clk);
            checkOutput("resp_wb_pulse", wb_valid_o, 1'b0);
            checkOutput("resp_ready", in_ready_o, 1'b1);
        end
    endtask

    initial begin
        int cnt;
        int kind;
        int sz;
        rst           = 1'b1;
        in_valid_i    = 1'b0;
        rd_wr_en_i    = 1'b0;
        rd_idx_i      = '0;
        alu_res_i     = '0;
        ls_info_bus_i = '0;
        rs2_store_i   = '0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", in_ready_o, 1'b1);
        checkOutput("rst_req", mem_req_o, 1'b0);
        checkOutput("rst_we", mem_we_o, 1'b0);
        checkOutput("rst_wmask", mem_wmask_o, 8'h00);
        checkOutput("rst_wb_valid", wb_valid_o, 1'b0);
        checkOutput("rst_wr_en", rd_wr_en_o, 1'b0);
        checkOutput("rst_err", ls_err_o, 1'b0);
        checkOutput("rst_wdata", rd_wdata_o, 64'h0);
        checkOutput("rst_idx", rd_idx_o, 5'd0);
        checkOutput("rst_addr", mem_addr_o, 64'h0);
        checkOutput("rst_mem_wdata", mem_wdata_o, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // lbu with immediate grant and data: writeback 3 cycles after accept
        applyStimulus(1, 0, 1'b1, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 1'b1, 5'd5, 0, 0);
        checkOutput("lbu_value", rd_wdata_o, 64'h80);
        // lh with a negative halfword in the top lanes
        applyStimulus(1, 1, 1'b0, 64'h8000_0006, 64'h0, 64'hFFFE_0000_0000_0000, 1'b1, 5'd6, 1, 2);
        checkOutput("lh_value", rd_wdata_o, 64'hFFFF_FFFF_FFFF_FFFE);
        // sw into the upper word
        applyStimulus(2, 2, 1'b0, 64'h8000_0004, 64'h1234_5678, 64'h0, 1'b1, 5'd7, 2, 0);
        // Misaligned ld
        applyStimulus(1, 3, 1'b0, 64'h8000_0004, 64'h0, 64'h0, 1'b1, 5'd8, 0, 0);
        // Plain ALU pass-through
        applyStimulus(0, 0, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'h0, 64'h0, 1'b1, 5'd9, 0, 0);

        // sb that is never granted: request held for the full timeout
        ls_info_bus_i = 7'b000_1010;
        alu_res_i     = 64'h8000_0001;
        rs2_store_i   = 64'hAB;
        rd_wr_en_i    = 1'b1;
        in_valid_i    = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        checkOutput("to_wmask", mem_wmask_o, 8'h02);
        cnt = 0;
        while (mem_req_o && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("to_req_cycles", cnt, 255);
        checkOutput("to_wb_valid", wb_valid_o, 1'b1);
        checkOutput("to_err", ls_err_o, 1'b1);
        checkOutput("to_wr_en", rd_wr_en_o, 1'b0);
        @(negedge clk);
        checkOutput("to_ready", in_ready_o, 1'b1);

        // Reset while waiting for read data; late rvalid must be ignored
        ls_info_bus_i = 7'b100_0001;
        alu_res_i     = 64'h8000_0008;
        rd_wr_en_i    = 1'b1;
        in_valid_i    = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        mem_gnt_i  = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h1122_3344_5566_7788;
        checkOutput("rw_req", mem_req_o, 1'b0);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        checkOutput("rw_no_wb", wb_valid_o, 1'b0);
        checkOutput("rw_ready", in_ready_o, 1'b1);
        @(negedge clk);
        checkOutput("rw_no_wb_late", wb_valid_o, 1'b0);

        // Randomized mix of operations
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            sz   = $urandom_range(0, 3);
            applyStimulus(kind, sz, 1'($urandom_range(0, 1)),
                          64'h8000_0000 | 64'($urandom_range(0, 255)),
                          {$urandom, $urandom}, {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
